life_array_grid: RTL and testbench

Parametrised ROWS x COLS Game-of-Life tile, rule B3/S23. It holds one register per cell and supports random-access cell writes and a serial scan chain that can load or unload the whole grid. It adds three things the 4x4 column-built tile does not have:
- a toroidal wrap mode;
- a counted single-step engine with busy/done handshake;
- generation count, stability and extinction status.

The block sits where the fixed 4x4 tile sits. It can be tiled through its halo inputs or run standalone as a torus.

---
 rtl/life_array_grid.sv | 160 ++++++++++++++++
 tb/tb_life_array_grid.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_array_grid.sv
// ROWS x COLS Game-of-Life tile (B3/S23) with halo or torus edges, a row-major scan chain,
// random-access writes and a counted single-step engine with generation/stability status.
module life_array_grid #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ROWS*COLS-1:0]   alive,
    input  logic [RW-1:0]          row,
    input  logic [CW-1:0]          col,
    input  logic                   val,
    input  logic                   write_enb,
    input  logic                   scan,
    input  logic                   scan_write_val,
    input  logic                   scan_write_enb,
    output logic                   scan_read_val,
    input  logic                   run,
    input  logic                   step,
    input  logic [GEN_W-1:0]       step_count,
    input  logic                   wrap,
    input  logic [COLS-1:0]        n,
    input  logic [COLS-1:0]        s,
    input  logic [ROWS-1:0]        w,
    input  logic [ROWS-1:0]        e,
    input  logic                   nw,
    input  logic                   ne,
    input  logic                   sw,
    input  logic                   se,
    output logic                   busy,
    output logic                   done,
    output logic [GEN_W-1:0]       gen_count,
    output logic                   stable,
    output logic                   extinct
);

    typedef enum logic {IDLE, STEP} state_t;

    state_t             state;
    logic [GEN_W-1:0]   remaining;
    logic               gen_en;
    logic               pad [ROWS+2][COLS+2];
    logic [3:0]         cnt;
    logic [ROWS*COLS-1:0] life_next;
    logic [ROWS*COLS-1:0] scan_next;

    function automatic logic life_rule(input logic cur, input logic [3:0] nbrs);
        return (nbrs == 4'd3) | (cur & (nbrs == 4'd2));
    endfunction

    assign gen_en        = (run | busy) & ~write_enb & ~scan & ~reset;
    assign scan_read_val = alive[ROWS*COLS-1];
    assign extinct       = ~|alive;

    // Grid framed by one ring of neighbours: either the halo inputs or the wrapped opposite edge.
    always_comb begin
        for (int r = 0; r < ROWS + 2; r++)
            for (int c = 0; c < COLS + 2; c++)
                pad[r][c] = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                pad[r+1][c+1] = alive[c*ROWS+r];
        for (int c = 0; c < COLS; c++) begin
            pad[0][c+1]      = wrap ? alive[c*ROWS+ROWS-1] : n[c];
            pad[ROWS+1][c+1] = wrap ? alive[c*ROWS]        : s[c];
        end
        for (int r = 0; r < ROWS; r++) begin
            pad[r+1][0]      = wrap ? alive[(COLS-1)*ROWS+r] : w[r];
            pad[r+1][COLS+1] = wrap ? alive[r]               : e[r];
        end
        pad[0][0]           = wrap ? alive[ROWS*COLS-1]       : nw;
        pad[0][COLS+1]      = wrap ? alive[ROWS-1]            : ne;
        pad[ROWS+1][0]      = wrap ? alive[(COLS-1)*ROWS]     : sw;
        pad[ROWS+1][COLS+1] = wrap ? alive[0]                 : se;
    end

    always_comb begin
        life_next = '0;
        cnt       = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cnt = 4'(pad[r][c])   + 4'(pad[r][c+1])   + 4'(pad[r][c+2]) +
                      4'(pad[r+1][c])                     + 4'(pad[r+1][c+2]) +
                      4'(pad[r+2][c]) + 4'(pad[r+2][c+1]) + 4'(pad[r+2][c+2]);
                life_next[c*ROWS+r] = life_rule(pad[r+1][c+1], cnt);
            end
        end
    end

    // Chain runs row-major from cell(0,0) to cell(ROWS-1,COLS-1).
    always_comb begin
        scan_next = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (c > 0)
                    scan_next[c*ROWS+r] = alive[(c-1)*ROWS+r];
                else if (r > 0)
                    scan_next[r] = alive[(COLS-1)*ROWS+r-1];
                else
                    scan_next[0] = scan_write_enb ? scan_write_val : alive[ROWS*COLS-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (reset) begin
            alive     <= '0;
            state     <= IDLE;
            busy      <= 1'b0;
            remaining <= '0;
            gen_count <= '0;
            stable    <= 1'b0;
        end else begin
            if (write_enb) begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        if (row == RW'(r) && col == CW'(c))
                            alive[c*ROWS+r] <= val;
                stable <= 1'b0;
            end else if (scan) begin
                alive  <= scan_next;
                stable <= 1'b0;
            end else if (gen_en) begin
                alive     <= life_next;
                gen_count <= gen_count + GEN_W'(1);
                stable    <= (life_next == alive);
            end

            case (state)
                IDLE: begin
                    if (step) begin
                        if (step_count != '0) begin
                            state     <= STEP;
                            busy      <= 1'b1;
                            remaining <= step_count;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    if (gen_en) begin
                        if (remaining == GEN_W'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                        remaining <= remaining - GEN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_life_array_grid.sv
// Bench for life_array_grid: directed scenarios with literal expectations plus randomized
// traffic, all compared every cycle against a cell-array reference model.
module tb_life_array_grid;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int GEN_W = 16;
    localparam int NC    = ROWS * COLS;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NC-1:0]     alive;
    logic [2:0]        row = '0, col = '0;
    logic              val = 1'b0, write_enb = 1'b0, scan = 1'b0;
    logic              scan_write_val = 1'b0, scan_write_enb = 1'b0, scan_read_val;
    logic              run = 1'b0, step = 1'b0, wrap = 1'b0;
    logic [GEN_W-1:0]  step_count = '0;
    logic [COLS-1:0]   n = '0, s = '0;
    logic [ROWS-1:0]   w = '0, e = '0;
    logic              nw = 1'b0, ne = 1'b0, sw = 1'b0, se = 1'b0;
    logic              busy, done, stable, extinct;
    logic [GEN_W-1:0]  gen_count;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit               m [ROWS][COLS];
    bit               mbusy, mdone, mstable, mvalid;
    int               mrem;
    logic [GEN_W-1:0] mgen;

    life_array_grid #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
        .clk(clk), .reset(reset), .alive(alive), .row(row), .col(col), .val(val),
        .write_enb(write_enb), .scan(scan), .scan_write_val(scan_write_val),
        .scan_write_enb(scan_write_enb), .scan_read_val(scan_read_val),
        .run(run), .step(step), .step_count(step_count), .wrap(wrap),
        .n(n), .s(s), .w(w), .e(e), .nw(nw), .ne(ne), .sw(sw), .se(se),
        .busy(busy), .done(done), .gen_count(gen_count), .stable(stable), .extinct(extinct)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit nb(int r, int c);
        if (r >= 0 && r < ROWS && c >= 0 && c < COLS) return m[r][c];
        if (wrap) return m[(r + ROWS) % ROWS][(c + COLS) % COLS];
        if (r < 0 && c < 0) return nw;
        if (r < 0 && c >= COLS) return ne;
        if (r >= ROWS && c < 0) return sw;
        if (r >= ROWS && c >= COLS) return se;
        if (r < 0) return n[c];
        if (r >= ROWS) return s[c];
        if (c < 0) return w[r];
        return e[r];
    endfunction

    function automatic logic [NC-1:0] pack_model();
        logic [NC-1:0] v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[c*ROWS+r] = m[r][c];
        return v;
    endfunction

    task automatic model_step();
        bit nm [ROWS][COLS];
        bit chain [NC];
        bit ge, nd, changed;
        int cnt;
        if (reset) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    m[r][c] = 1'b0;
            mbusy = 0; mdone = 0; mstable = 0; mrem = 0; mgen = '0; mvalid = 1;
        end else begin
            ge = (run || mbusy) && !write_enb && !scan;
            nd = 0;
            if (write_enb) begin
                if (int'(row) < ROWS && int'(col) < COLS) m[row][col] = val;
                mstable = 0;
            end else if (scan) begin
                for (int k = 0; k < NC; k++) chain[k] = m[k / COLS][k % COLS];
                m[0][0] = scan_write_enb ? scan_write_val : chain[NC-1];
                for (int k = 1; k < NC; k++) m[k / COLS][k % COLS] = chain[k-1];
                mstable = 0;
            end else if (ge) begin
                changed = 0;
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        cnt = 0;
                        for (int dr = -1; dr <= 1; dr++)
                            for (int dc = -1; dc <= 1; dc++)
                                if (dr != 0 || dc != 0) cnt += int'(nb(r + dr, c + dc));
                        nm[r][c] = (cnt == 3) || (m[r][c] && cnt == 2);
                        if (nm[r][c] != m[r][c]) changed = 1;
                    end
                end
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        m[r][c] = nm[r][c];
                mstable = !changed;
                mgen = mgen + 1'b1;
            end
            if (!mbusy) begin
                if (step) begin
                    if (step_count != 0) begin mbusy = 1; mrem = int'(step_count); end
                    else nd = 1;
                end
            end else if (ge) begin
                mrem--;
                if (mrem == 0) begin mbusy = 0; nd = 1; end
            end
            mdone = nd;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        reset = 0; write_enb = 0; scan = 0; run = 0; step = 0; step_count = '0;
    endtask

    task automatic wr(input int r, input int c, input bit v);
        row = 3'(r); col = 3'(c); val = v; write_enb = 1;
        tick();
        write_enb = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                check("alive", alive, pack_model());
                check("busy", busy, mbusy);
                check("done", done, mdone);
                check("gen_count", gen_count, mgen);
                check("stable", stable, mstable);
                check("extinct", extinct, (pack_model() == '0));
                check("scan_read_val", scan_read_val, m[ROWS-1][COLS-1]);
            end
        end
    end

    initial begin
        logic [63:0] exp_v, glider, d;
        int busy_n, done_n;

        // Reset state
        tick(); tick();
        reset = 0;
        check("rst_alive", alive, 64'h0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_gen", gen_count, 0);
        check("rst_stable", stable, 0);
        check("rst_extinct", extinct, 1);
        check("rst_scan_read", scan_read_val, 0);

        // Blinker, edges from zero halos
        wr(3, 2, 1); wr(3, 3, 1); wr(3, 4, 1);
        run = 1;
        tick();
        check("blinker_vert", alive, (64'h1 << 26) | (64'h1 << 27) | (64'h1 << 28));
        tick();
        run = 0;
        check("blinker_horz", alive, (64'h1 << 19) | (64'h1 << 27) | (64'h1 << 35));
        check("blinker_gen", gen_count, 2);
        check("blinker_stable", stable, 0);

        // Birth driven by the north halo
        do_reset();
        n = 8'b0001_1100;
        run = 1;
        tick();
        check("halo_birth", alive, 64'h1 << 24);
        n = '0;
        tick();
        run = 0;
        check("halo_extinct", extinct, 1);

        // Glider on the torus returns home after 32 generations
        do_reset();
        wrap = 1;
        wr(0, 1, 1); wr(1, 2, 1); wr(2, 0, 1); wr(2, 1, 1); wr(2, 2, 1);
        glider = (64'h1 << 8) | (64'h1 << 17) | (64'h1 << 2) | (64'h1 << 10) | (64'h1 << 18);
        check("glider_load", alive, glider);
        step = 1; step_count = 16'd32;
        tick();
        step = 0; step_count = '0;
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 40; i++) begin
            busy_n += int'(busy);
            done_n += int'(done);
            tick();
        end
        check("glider_busy_cycles", busy_n, 32);
        check("glider_done_pulses", done_n, 1);
        check("glider_grid", alive, glider);
        check("glider_gen", gen_count, 32);
        wrap = 0;

        // Scan load then recirculating unload
        do_reset();
        d = 64'hA5A5_0F0F_3C3C_FFFF;
        scan = 1; scan_write_enb = 1;
        for (int i = 0; i < 64; i++) begin
            scan_write_val = d[63-i];
            tick();
        end
        exp_v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                exp_v[c*ROWS+r] = d[r*COLS+c];
        check("scan_load", alive, exp_v);
        scan_write_enb = 0;
        for (int i = 0; i < 64; i++) begin
            check("scan_read_order", scan_read_val, d[63-i]);
            tick();
        end
        scan = 0;
        check("scan_recirc", alive, exp_v);

        // step_count of zero: done only
        do_reset();
        step = 1; step_count = '0;
        tick();
        step = 0;
        check("step0_done", done, 1);
        check("step0_busy", busy, 0);
        check("step0_gen", gen_count, 0);

        // Stalled step run on a still-life block
        do_reset();
        wr(1, 1, 1); wr(1, 2, 1); wr(2, 1, 1); wr(2, 2, 1);
        step = 1; step_count = 16'd5;
        tick();
        step = 0; step_count = '0;
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) check("block_stable", stable, 1);
            busy_n += int'(busy);
            done_n += int'(done);
            row = 3'd1; col = 3'd1; val = 1;
            write_enb = (i == 2 || i == 3);
            tick();
        end
        write_enb = 0;
        check("stall_busy_cycles", busy_n, 7);
        check("stall_done_pulses", done_n, 1);
        check("stall_gen", gen_count, 5);

        // Reset in the middle of a step run
        do_reset();
        wr(1, 1, 1); wr(1, 2, 1); wr(2, 1, 1);
        step = 1; step_count = 16'd10;
        tick();
        step = 0; step_count = '0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        check("midrst_busy", busy, 0);
        check("midrst_alive", alive, 64'h0);
        check("midrst_gen", gen_count, 0);
        done_n = 0;
        for (int i = 0; i < 5; i++) begin
            done_n += int'(done);
            tick();
        end
        check("midrst_no_done", done_n, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 299) == 0);
            write_enb      = ($urandom_range(0, 7) == 0);
            row            = 3'($urandom);
            col            = 3'($urandom);
            val            = 1'($urandom);
            scan           = ($urandom_range(0, 7) == 0);
            scan_write_enb = 1'($urandom);
            scan_write_val = 1'($urandom);
            run            = ($urandom_range(0, 2) == 0);
            step           = ($urandom_range(0, 11) == 0);
            step_count     = 16'($urandom_range(0, 6));
            if (i % 200 == 0) wrap = 1'($urandom);
            n  = 8'($urandom & $urandom);
            s  = 8'($urandom & $urandom);
            w  = 8'($urandom & $urandom);
            e  = 8'($urandom & $urandom);
            nw = 1'($urandom); ne = 1'($urandom); sw = 1'($urandom); se = 1'($urandom);
            tick();
        end
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
